// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter: merges ALU and load results into an in-order FIFO feeding the regfile write port
module wb_arbiter #(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 4,
    parameter bit DROP_R0   = 1'b1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [4:0]             alu_reg,
    input  logic [DATAWIDTH-1:0]   alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [4:0]             mem_reg,
    input  logic [DATAWIDTH-1:0]   mem_data,
    output logic                   write,
    output logic [4:0]             writeReg,
    output logic [DATAWIDTH-1:0]   writeData,
    input  logic [4:0]             chk_reg,
    output logic                   hazard,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]           r_reg_mem  [DEPTH];
    logic [DATAWIDTH-1:0] r_data_mem [DEPTH];
    logic [AW-1:0]        r_head;
    logic [AW-1:0]        r_tail;
    logic [CW-1:0]        r_count;
    logic                 r_write;
    logic [4:0]           r_write_reg;
    logic [DATAWIDTH-1:0] r_write_data;

    logic                 w_full;
    logic                 w_mem_push;
    logic                 w_alu_push;
    logic                 w_push;
    logic                 w_pop;
    logic [4:0]           w_push_reg;
    logic [DATAWIDTH-1:0] w_push_data;
    logic                 w_hazard;

    // Readies depend only on registered occupancy and flush; memory wins over ALU.
    assign w_full      = (r_count == CW'(DEPTH));
    assign mem_ready   = !w_full && !flush;
    assign alu_ready   = !w_full && !flush && !mem_valid;
    assign w_mem_push  = mem_valid && mem_ready;
    assign w_alu_push  = alu_valid && alu_ready;
    assign w_push      = w_mem_push || w_alu_push;
    assign w_push_reg  = w_mem_push ? mem_reg  : alu_reg;
    assign w_push_data = w_mem_push ? mem_data : alu_data;
    assign w_pop       = (r_count != '0) && !flush;

    assign write     = r_write;
    assign writeReg  = r_write_reg;
    assign writeData = r_write_data;
    assign count     = r_count;
    assign hazard    = w_hazard;

    // Storage is not reset: only entries inside head..head+count-1 are ever observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_reg_mem[r_tail]  <= w_push_reg;
            r_data_mem[r_tail] <= w_push_data;
        end
    end

    // Pointer, occupancy and write-port registers; flush discards everything pending.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_write      <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_write <= 1'b0;
        end else begin
            if (w_pop) begin
                r_write_reg  <= r_reg_mem[r_head];
                r_write_data <= r_data_mem[r_head];
                r_write      <= !(DROP_R0 && (r_reg_mem[r_head] == 5'd0));
                r_head       <= r_head + 1'b1;
            end else begin
                r_write <= 1'b0;
            end
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Hazard scans queued entries only; the entry on the write port is forwarded by the regfile.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && (chk_reg != 5'd0) &&
                (r_reg_mem[r_head + AW'(i)] == chk_reg)) begin
                w_hazard = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter against a queue-based reference model
module tb_wb_arbiter;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          flush;
    logic          alu_valid;
    logic          alu_ready;
    logic [4:0]    alu_reg;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [4:0]    mem_reg;
    logic [DW-1:0] mem_data;
    logic          write;
    logic [4:0]    writeReg;
    logic [DW-1:0] writeData;
    logic [4:0]    chk_reg;
    logic          hazard;
    logic [2:0]    count;

    wb_arbiter #(.DATAWIDTH(DW), .DEPTH(DEPTH), .DROP_R0(1'b1)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .write(write), .writeReg(writeReg), .writeData(writeData),
        .chk_reg(chk_reg), .hazard(hazard), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]    r;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic          m_write;
    logic [4:0]    m_reg;
    logic [DW-1:0] m_data;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_write = 1'b0;
        m_reg   = '0;
        m_data  = '0;
    endtask

    // One clock: drive, check combinational outputs, clock, advance model, check registered outputs.
    task automatic step(input logic fl, input logic av, input logic [4:0] ar, input logic [DW-1:0] ad,
                        input logic mv, input logic [4:0] mr, input logic [DW-1:0] md, input logic [4:0] cr);
        logic full, exp_mr, exp_ar, exp_hz;
        ent_t e;
        flush = fl; alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md; chk_reg = cr;
        #1;
        full   = (q.size() == DEPTH);
        exp_mr = !full && !fl;
        exp_ar = !full && !fl && !mv;
        exp_hz = 1'b0;
        foreach (q[i]) if (cr != 0 && q[i].r == cr) exp_hz = 1'b1;
        check("mem_ready", 64'(mem_ready), 64'(exp_mr));
        check("alu_ready", 64'(alu_ready), 64'(exp_ar));
        check("hazard",    64'(hazard),    64'(exp_hz));
        check("count_pre", 64'(count),     64'(q.size()));
        @(posedge clk);
        if (fl) begin
            q.delete();
            m_write = 1'b0;
        end else begin
            if (q.size() > 0) begin
                e = q.pop_front();
                m_write = (e.r != 0);
                m_reg   = e.r;
                m_data  = e.d;
            end else begin
                m_write = 1'b0;
            end
            if (mv && exp_mr) q.push_back('{r: mr, d: md});
            else if (av && exp_ar) q.push_back('{r: ar, d: ad});
        end
        #1;
        check("write",     64'(write),     64'(m_write));
        check("writeReg",  64'(writeReg),  64'(m_reg));
        check("writeData", 64'(writeData), 64'(m_data));
        check("count",     64'(count),     64'(q.size()));
    endtask

    task automatic idle(input logic [4:0] cr);
        step(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, cr);
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0; chk_reg = '0;
        model_reset();
        #2;
        check("rst_write",     64'(write),     64'd0);
        check("rst_count",     64'(count),     64'd0);
        check("rst_writeReg",  64'(writeReg),  64'd0);
        check("rst_writeData", 64'(writeData), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        idle(5'd0);
        idle(5'd0);

        // Single ALU push and its fixed two-edge latency.
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0, 5'd5);
        check("single_count1", 64'(count), 64'd1);
        idle(5'd5);
        check("single_write",  64'(write),     64'd1);
        check("single_reg",    64'(writeReg),  64'd5);
        check("single_data",   64'(writeData), 64'hDEADBEEF);
        idle(5'd0);
        check("single_write_off", 64'(write), 64'd0);

        // Memory priority over ALU.
        step(1'b0, 1'b1, 5'd4, 32'h4444, 1'b1, 5'd3, 32'h3331, 5'd3);
        step(1'b0, 1'b1, 5'd4, 32'h4444, 1'b1, 5'd3, 32'h3332, 5'd3);
        step(1'b0, 1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, '0, 5'd4);
        idle(5'd4);
        idle(5'd0);

        // Back-to-back pushes wrap the pointers while occupancy stays at one.
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b1, 5'(i), 32'(i * 16), 1'b0, 5'd0, '0, 5'(i));
            check("wrap_count_le1", 64'(count <= 3'd1), 64'd1);
        end
        idle(5'd6);
        check("wrap_last_reg",  64'(writeReg),  64'd6);
        check("wrap_last_data", 64'(writeData), 64'h60);
        idle(5'd0);

        // Hazard on a queued reg 7, never on reg 0, then flush discards the reg-0 entry.
        step(1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, '0, 5'd7);
        check("hz_queued", 64'(hazard), 64'd1);
        step(1'b0, 1'b1, 5'd0, 32'h00, 1'b0, 5'd0, '0, 5'd7);
        check("hz_after_port", 64'(hazard), 64'd0);
        step(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_write", 64'(write), 64'd0);
        idle(5'd0);
        idle(5'd0);

        // Asynchronous reset mid-cycle with an entry pending.
        step(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd9, 32'h99, 5'd9);
        mem_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_write", 64'(write), 64'd0);
        model_reset();
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        idle(5'd9);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                 5'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
